// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester handshakes and byte-controller signals for i2c_txn_arbiter.
// slave = the arbiter side, master = requesters plus byte controller.
interface i2c_txn_arbiter_if;
  logic        req_a_valid, req_b_valid;
  logic        req_a_rw, req_b_rw;
  logic [15:0] req_a_reg, req_b_reg;
  logic [10:0] req_a_len, req_b_len;
  logic [7:0]  wr_a_data, wr_b_data;
  logic        grant_a, grant_b;
  logic        wr_a_take, wr_b_take;
  logic [7:0]  rd_data;
  logic        rd_a_valid, rd_b_valid;
  logic        done_a, done_b;
  logic        err_a, err_b;
  logic        busy;
  logic [6:0]  i2c_address;
  logic        i2c_read_write;
  logic [7:0]  i2c_transmit_data;
  logic        i2c_enable_transfer;
  logic        i2c_idle, i2c_ack, i2c_nack;
  logic [7:0]  i2c_received_data;

  modport slave (
    input  req_a_valid, req_b_valid, req_a_rw, req_b_rw, req_a_reg, req_b_reg,
           req_a_len, req_b_len, wr_a_data, wr_b_data,
           i2c_idle, i2c_ack, i2c_nack, i2c_received_data,
    output grant_a, grant_b, wr_a_take, wr_b_take, rd_data, rd_a_valid, rd_b_valid,
           done_a, done_b, err_a, err_b, busy,
           i2c_address, i2c_read_write, i2c_transmit_data, i2c_enable_transfer
  );

  modport master (
    output req_a_valid, req_b_valid, req_a_rw, req_b_rw, req_a_reg, req_b_reg,
           req_a_len, req_b_len, wr_a_data, wr_b_data,
           i2c_idle, i2c_ack, i2c_nack, i2c_received_data,
    input  grant_a, grant_b, wr_a_take, wr_b_take, rd_data, rd_a_valid, rd_b_valid,
           done_a, done_b, err_a, err_b, busy,
           i2c_address, i2c_read_write, i2c_transmit_data, i2c_enable_transfer
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter for two register-access requesters sharing one I2C byte
// controller: sends a 16-bit register address, then reads or writes len bytes.
module i2c_txn_arbiter #(
  parameter logic [6:0] DEV_ADDR      = 7'h33,
  parameter int         TIMEOUT_TICKS = 24000
) (
  input logic              clk,
  input logic              reset,
  i2c_txn_arbiter_if.slave bus
);
  localparam int            TW       = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, REG_HI, REG_LO, SWITCH, DATA, STOP, ERROR} state_t;

  state_t        state_q, state_d;
  logic          own_b_q, own_b_d, prio_b_q, prio_b_d, rw_q, rw_d;
  logic [15:0]   reg_q, reg_d;
  logic [10:0]   len_q, len_d, cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    ack_sh_q, ack_sh_d, nack_sh_q, nack_sh_d;
  logic          en_q, en_d, rdwr_q, rdwr_d, busy_q, busy_d;
  logic [7:0]    tx_q, tx_d, rd_data_q, rd_data_d;
  logic          grant_d, take_d, rdv_d, done_d, err_d;
  logic          grant_a_q, grant_b_q, take_a_q, take_b_q, rdv_a_q, rdv_b_q;
  logic          done_a_q, done_b_q, err_a_q, err_b_q;
  logic          pick_b, fail, succ, byte_abort;
  logic [15:0]   sel_reg;
  logic [7:0]    wr_byte;

  always_comb begin
    pick_b     = bus.req_b_valid && (!bus.req_a_valid || prio_b_q);
    sel_reg    = pick_b ? bus.req_b_reg : bus.req_a_reg;
    wr_byte    = own_b_q ? bus.wr_b_data : bus.wr_a_data;
    ack_sh_d   = {ack_sh_q[0], bus.i2c_ack};
    nack_sh_d  = {nack_sh_q[0], bus.i2c_nack};
    // A failure edge outranks a success edge arriving in the same cycle.
    fail       = (nack_sh_q == 2'b01);
    succ       = (ack_sh_q == 2'b01) && !fail;
    byte_abort = fail || (!succ && tmo_q == TMO_LAST);

    state_d = state_q;  own_b_d = own_b_q;  prio_b_d = prio_b_q;  rw_d = rw_q;
    reg_d = reg_q;  len_d = len_q;  cnt_d = cnt_q;  tmo_d = tmo_q;
    en_d = en_q;  rdwr_d = rdwr_q;  busy_d = busy_q;  tx_d = tx_q;  rd_data_d = rd_data_q;
    grant_d = 1'b0;  take_d = 1'b0;  rdv_d = 1'b0;  done_d = 1'b0;  err_d = 1'b0;

    if (state_q inside {REG_HI, REG_LO, DATA}) tmo_d = tmo_q + TW'(1);

    case (state_q)
      IDLE: if (bus.i2c_idle && (bus.req_a_valid || bus.req_b_valid)) begin
        own_b_d  = pick_b;
        prio_b_d = !pick_b;
        rw_d     = pick_b ? bus.req_b_rw  : bus.req_a_rw;
        len_d    = pick_b ? bus.req_b_len : bus.req_a_len;
        reg_d    = sel_reg;
        tx_d     = sel_reg[15:8];
        grant_d  = 1'b1;
        busy_d   = 1'b1;
        en_d     = 1'b1;
        rdwr_d   = 1'b0;
        tmo_d    = '0;
        state_d  = REG_HI;
      end
      REG_HI: if (byte_abort) begin
        en_d = 1'b0;  state_d = ERROR;
      end else if (succ) begin
        tx_d = reg_q[7:0];  tmo_d = '0;  state_d = REG_LO;
      end
      REG_LO: if (byte_abort) begin
        en_d = 1'b0;  state_d = ERROR;
      end else if (succ) begin
        tmo_d = '0;
        if (len_q == '0) begin
          en_d = 1'b0;  state_d = STOP;
        end else if (rw_q) begin
          en_d = 1'b0;  rdwr_d = 1'b1;  state_d = SWITCH;
        end else begin
          cnt_d = len_q;  tx_d = wr_byte;  take_d = 1'b1;  state_d = DATA;
        end
      end
      // Enable stays low until the controller is idle so it issues a repeated start.
      SWITCH: if (bus.i2c_idle) begin
        en_d = 1'b1;  cnt_d = len_q;  tmo_d = '0;  state_d = DATA;
      end
      DATA: if (byte_abort) begin
        en_d = 1'b0;  state_d = ERROR;
      end else if (succ) begin
        tmo_d = '0;
        cnt_d = cnt_q - 11'd1;
        if (rw_q) begin
          rd_data_d = bus.i2c_received_data;  rdv_d = 1'b1;
        end
        if (cnt_q == 11'd1) begin
          en_d = 1'b0;  state_d = STOP;
        end else if (!rw_q) begin
          tx_d = wr_byte;  take_d = 1'b1;
        end
      end
      STOP: if (bus.i2c_idle) begin
        done_d = 1'b1;  busy_d = 1'b0;  rdwr_d = 1'b0;  state_d = IDLE;
      end
      ERROR: if (bus.i2c_idle) begin
        err_d = 1'b1;  busy_d = 1'b0;  rdwr_d = 1'b0;  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;  own_b_q <= 1'b0;  prio_b_q <= 1'b0;  rw_q <= 1'b0;
      reg_q <= '0;  len_q <= '0;  cnt_q <= '0;  tmo_q <= '0;
      ack_sh_q <= '0;  nack_sh_q <= '0;
      en_q <= 1'b0;  rdwr_q <= 1'b0;  busy_q <= 1'b0;  tx_q <= '0;  rd_data_q <= '0;
      grant_a_q <= 1'b0;  grant_b_q <= 1'b0;  take_a_q <= 1'b0;  take_b_q <= 1'b0;
      rdv_a_q <= 1'b0;  rdv_b_q <= 1'b0;  done_a_q <= 1'b0;  done_b_q <= 1'b0;
      err_a_q <= 1'b0;  err_b_q <= 1'b0;
    end else begin
      state_q <= state_d;  own_b_q <= own_b_d;  prio_b_q <= prio_b_d;  rw_q <= rw_d;
      reg_q <= reg_d;  len_q <= len_d;  cnt_q <= cnt_d;  tmo_q <= tmo_d;
      ack_sh_q <= ack_sh_d;  nack_sh_q <= nack_sh_d;
      en_q <= en_d;  rdwr_q <= rdwr_d;  busy_q <= busy_d;  tx_q <= tx_d;  rd_data_q <= rd_data_d;
      grant_a_q <= grant_d & ~own_b_d;  grant_b_q <= grant_d & own_b_d;
      take_a_q  <= take_d & ~own_b_q;   take_b_q  <= take_d & own_b_q;
      rdv_a_q   <= rdv_d & ~own_b_q;    rdv_b_q   <= rdv_d & own_b_q;
      done_a_q  <= done_d & ~own_b_q;   done_b_q  <= done_d & own_b_q;
      err_a_q   <= err_d & ~own_b_q;    err_b_q   <= err_d & own_b_q;
    end
  end

  assign bus.grant_a             = grant_a_q;
  assign bus.grant_b             = grant_b_q;
  assign bus.wr_a_take           = take_a_q;
  assign bus.wr_b_take           = take_b_q;
  assign bus.rd_data             = rd_data_q;
  assign bus.rd_a_valid          = rdv_a_q;
  assign bus.rd_b_valid          = rdv_b_q;
  assign bus.done_a              = done_a_q;
  assign bus.done_b              = done_b_q;
  assign bus.err_a               = err_a_q;
  assign bus.err_b               = err_b_q;
  assign bus.busy                = busy_q;
  assign bus.i2c_address         = DEV_ADDR;
  assign bus.i2c_read_write      = rdwr_q;
  assign bus.i2c_transmit_data   = tx_q;
  assign bus.i2c_enable_transfer = en_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a simple byte-controller model that
// acks after a fixed latency and goes idle a few cycles after enable drops.
module tb_i2c_txn_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_txn_arbiter_if bus();
  i2c_txn_arbiter #(.DEV_ADDR(7'h33), .TIMEOUT_TICKS(50)) dut (.clk(clk), .reset(reset), .bus(bus));

  localparam int LAT = 4, IDLE_WAIT = 4;
  int errors = 0, checks = 0;

  // Controller model configuration, written only by the stimulus block.
  int nack_idx = -1, both_idx = -1, silent_from = -1, log_base = 0;
  logic [7:0] log_tx[$];
  logic       log_rw[$];
  int lat_cnt = 0, iw = 0, bidx = 0;

  always @(posedge clk) begin
    #1;
    bus.i2c_ack  = 1'b0;
    bus.i2c_nack = 1'b0;
    if (reset === 1'b1) begin
      bus.i2c_idle = 1'b1;  bus.i2c_received_data = 8'h00;  lat_cnt = 0;  iw = 0;
    end else if (bus.i2c_enable_transfer === 1'b1) begin
      iw = 0;
      if (bus.i2c_idle === 1'b1) begin
        bus.i2c_idle = 1'b0;  lat_cnt = 0;
      end else begin
        lat_cnt++;
        bidx = log_tx.size() - log_base;
        if (lat_cnt >= LAT && !(silent_from >= 0 && bidx >= silent_from)) begin
          log_tx.push_back(bus.i2c_transmit_data);
          log_rw.push_back(bus.i2c_read_write);
          if (bidx == both_idx) begin
            bus.i2c_ack = 1'b1;  bus.i2c_nack = 1'b1;
          end else if (bidx == nack_idx) begin
            bus.i2c_nack = 1'b1;
          end else begin
            bus.i2c_ack = 1'b1;  bus.i2c_received_data = 8'hC0 + 8'(bidx);
          end
          lat_cnt = 0;
        end
      end
    end else if (bus.i2c_idle !== 1'b1) begin
      iw++;
      if (iw >= IDLE_WAIT) begin bus.i2c_idle = 1'b1;  iw = 0; end
    end
  end

  // Pulse monitor and write-data feeder.
  int n_ga = 0, n_gb = 0, n_ta = 0, n_tb = 0, n_ra = 0, n_rb = 0;
  int n_da = 0, n_db = 0, n_ea = 0, n_eb = 0, n_rw1 = 0, n_en_err = 0;
  logic [7:0] rd_log[$];
  int         gnt_log[$];
  logic [7:0] wdat_a[8], wdat_b[8];
  int b_ga, b_gb, b_ta = 0, b_tb = 0, b_ra, b_rb, b_da, b_db, b_ea, b_eb, b_rw1, b_en_err;
  int lb, rb, gb;

  always @(negedge clk) begin
    if (bus.grant_a === 1'b1) begin n_ga++; gnt_log.push_back(0); end
    if (bus.grant_b === 1'b1) begin n_gb++; gnt_log.push_back(1); end
    if (bus.wr_a_take === 1'b1) n_ta++;
    if (bus.wr_b_take === 1'b1) n_tb++;
    if (bus.rd_a_valid === 1'b1) begin n_ra++; rd_log.push_back(bus.rd_data); end
    if (bus.rd_b_valid === 1'b1) begin n_rb++; rd_log.push_back(bus.rd_data); end
    if (bus.done_a === 1'b1) n_da++;
    if (bus.done_b === 1'b1) n_db++;
    if (bus.err_a === 1'b1) n_ea++;
    if (bus.err_b === 1'b1) n_eb++;
    if ((bus.err_a === 1'b1 || bus.err_b === 1'b1) && bus.i2c_enable_transfer !== 1'b0) n_en_err++;
    if (bus.i2c_read_write === 1'b1) n_rw1++;
    bus.wr_a_data = wdat_a[(n_ta - b_ta) % 8];
    bus.wr_b_data = wdat_b[(n_tb - b_tb) % 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int ng();
    return n_ga + n_gb;
  endfunction

  function automatic int ne();
    return n_da + n_db + n_ea + n_eb;
  endfunction

  task automatic snap();
    b_ga = n_ga;  b_gb = n_gb;  b_ta = n_ta;  b_tb = n_tb;  b_ra = n_ra;  b_rb = n_rb;
    b_da = n_da;  b_db = n_db;  b_ea = n_ea;  b_eb = n_eb;  b_rw1 = n_rw1;  b_en_err = n_en_err;
    log_base = log_tx.size();  lb = log_tx.size();  rb = rd_log.size();  gb = gnt_log.size();
  endtask

  task automatic wait_grants(input int target, input string tag);
    for (int k = 0; k < 3000 && ng() < target; k++) step();
    check(tag, 32'(ng() >= target), 32'd1);
  endtask

  task automatic wait_end(input int target, input string tag);
    for (int k = 0; k < 3000 && ne() < target; k++) step();
    check(tag, 32'(ne() >= target), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tx[4];
    int g0, e0, n, m;
    reset = 1'b1;
    bus.req_a_valid = 1'b0;  bus.req_b_valid = 1'b0;
    bus.req_a_rw = 1'b0;  bus.req_b_rw = 1'b0;
    bus.req_a_reg = '0;  bus.req_b_reg = '0;  bus.req_a_len = '0;  bus.req_b_len = '0;
    for (int i = 0; i < 8; i++) begin wdat_a[i] = 8'h00; wdat_b[i] = 8'h00; end
    repeat (3) step();

    // Reset state
    check("rst_enable",  32'(bus.i2c_enable_transfer), 32'd0);
    check("rst_rw",      32'(bus.i2c_read_write), 32'd0);
    check("rst_tx",      32'(bus.i2c_transmit_data), 32'h00);
    check("rst_rd_data", 32'(bus.rd_data), 32'h00);
    check("rst_busy",    32'(bus.busy), 32'd0);
    check("rst_grants",  32'({bus.grant_a, bus.grant_b}), 32'd0);
    check("rst_addr",    32'(bus.i2c_address), 32'h33);
    reset = 1'b0;
    repeat (2) step();

    // Read A, reg 2400, len 4
    snap();  g0 = ng();  e0 = ne();
    bus.req_a_rw = 1'b1;  bus.req_a_reg = 16'h2400;  bus.req_a_len = 11'd4;  bus.req_a_valid = 1'b1;
    wait_grants(g0 + 1, "s1_grant");
    check("s1_busy_on", 32'(bus.busy), 32'd1);
    bus.req_a_valid = 1'b0;  bus.req_a_rw = 1'b0;  bus.req_a_reg = 16'hFFFF;  bus.req_a_len = 11'd0;
    wait_end(e0 + 1, "s1_end");
    check("s1_nbytes", 32'(log_tx.size() - lb), 32'd6);
    check("s1_tx_hi",  32'(log_tx[lb]), 32'h24);
    check("s1_tx_lo",  32'(log_tx[lb + 1]), 32'h00);
    check("s1_rw_reg", 32'(log_rw[lb + 1]), 32'd0);
    check("s1_rw_dat", 32'(log_rw[lb + 2]), 32'd1);
    check("s1_rdv",    32'(n_ra - b_ra), 32'd4);
    for (int i = 0; i < 4; i++) check("s1_rd_data", 32'(rd_log[rb + i]), 32'hC2 + 32'(i));
    check("s1_done",   32'(n_da - b_da), 32'd1);
    check("s1_err",    32'(n_ea - b_ea), 32'd0);
    check("s1_busy",   32'(bus.busy), 32'd0);

    // Write B, reg 800D, len 2, data 11 22
    wdat_b[0] = 8'h11;  wdat_b[1] = 8'h22;
    snap();  g0 = ng();  e0 = ne();
    step();
    bus.req_b_rw = 1'b0;  bus.req_b_reg = 16'h800D;  bus.req_b_len = 11'd2;  bus.req_b_valid = 1'b1;
    wait_grants(g0 + 1, "s2_grant");
    bus.req_b_valid = 1'b0;
    wait_end(e0 + 1, "s2_end");
    exp_tx[0] = 8'h80;  exp_tx[1] = 8'h0D;  exp_tx[2] = 8'h11;  exp_tx[3] = 8'h22;
    check("s2_nbytes", 32'(log_tx.size() - lb), 32'd4);
    for (int i = 0; i < 4; i++) check("s2_tx", 32'(log_tx[lb + i]), 32'(exp_tx[i]));
    check("s2_take",   32'(n_tb - b_tb), 32'd2);
    check("s2_rw_one", 32'(n_rw1 - b_rw1), 32'd0);
    check("s2_grant_b", 32'(n_gb - b_gb), 32'd1);
    check("s2_done",   32'(n_db - b_db), 32'd1);
    check("s2_err",    32'(n_eb - b_eb), 32'd0);

    // Round-robin: pointer favours A (B was last), then forced towards B
    bus.req_a_rw = 1'b0;  bus.req_a_reg = 16'h0101;  bus.req_a_len = 11'd0;
    bus.req_b_rw = 1'b0;  bus.req_b_reg = 16'h0202;  bus.req_b_len = 11'd0;
    snap();  g0 = ng();  e0 = ne();
    bus.req_a_valid = 1'b1;  bus.req_b_valid = 1'b1;
    wait_grants(g0 + 2, "s3_grants1");
    bus.req_a_valid = 1'b0;  bus.req_b_valid = 1'b0;
    wait_end(e0 + 2, "s3_end1");
    check("s3_first_a",  32'(gnt_log[gb]), 32'd0);
    check("s3_second_b", 32'(gnt_log[gb + 1]), 32'd1);
    snap();  g0 = ng();  e0 = ne();
    bus.req_a_valid = 1'b1;
    wait_grants(g0 + 1, "s3_grant_a");
    bus.req_a_valid = 1'b0;
    wait_end(e0 + 1, "s3_end_a");
    snap();  g0 = ng();  e0 = ne();
    bus.req_a_valid = 1'b1;  bus.req_b_valid = 1'b1;
    wait_grants(g0 + 2, "s3_grants2");
    bus.req_a_valid = 1'b0;  bus.req_b_valid = 1'b0;
    wait_end(e0 + 2, "s3_end2");
    check("s3_first_b",  32'(gnt_log[gb]), 32'd1);
    check("s3_second_a", 32'(gnt_log[gb + 1]), 32'd0);

    // NACK on REG_LO for a read from A
    snap();  g0 = ng();  e0 = ne();  nack_idx = 1;
    bus.req_a_rw = 1'b1;  bus.req_a_reg = 16'h1234;  bus.req_a_len = 11'd4;  bus.req_a_valid = 1'b1;
    wait_grants(g0 + 1, "s4_grant");
    bus.req_a_valid = 1'b0;
    wait_end(e0 + 1, "s4_end");
    check("s4_err",    32'(n_ea - b_ea), 32'd1);
    check("s4_done",   32'(n_da - b_da), 32'd0);
    check("s4_rdv",    32'(n_ra - b_ra), 32'd0);
    check("s4_nbytes", 32'(log_tx.size() - lb), 32'd2);
    check("s4_en_err", 32'(n_en_err - b_en_err), 32'd0);
    nack_idx = -1;
    wdat_a[0] = 8'h5A;
    snap();  g0 = ng();  e0 = ne();
    step();
    bus.req_a_rw = 1'b0;  bus.req_a_reg = 16'h0001;  bus.req_a_len = 11'd1;  bus.req_a_valid = 1'b1;
    wait_grants(g0 + 1, "s4b_grant");
    bus.req_a_valid = 1'b0;
    wait_end(e0 + 1, "s4b_end");
    check("s4b_nbytes", 32'(log_tx.size() - lb), 32'd3);
    check("s4b_tx_data", 32'(log_tx[lb + 2]), 32'h5A);
    check("s4b_done",   32'(n_da - b_da), 32'd1);
    check("s4b_err",    32'(n_ea - b_ea), 32'd0);

    // Simultaneous ack and nack edges count as failure
    snap();  g0 = ng();  e0 = ne();  both_idx = 0;
    bus.req_b_rw = 1'b0;  bus.req_b_reg = 16'h00F0;  bus.req_b_len = 11'd0;  bus.req_b_valid = 1'b1;
    wait_grants(g0 + 1, "sb_grant");
    bus.req_b_valid = 1'b0;
    wait_end(e0 + 1, "sb_end");
    check("sb_err",  32'(n_eb - b_eb), 32'd1);
    check("sb_done", 32'(n_db - b_db), 32'd0);
    both_idx = -1;

    // Silent controller during DATA: timeout after 50 cycles
    wdat_b[0] = 8'hAB;  wdat_b[1] = 8'hCD;
    snap();  g0 = ng();  e0 = ne();  silent_from = 2;
    step();
    bus.req_b_rw = 1'b0;  bus.req_b_reg = 16'h4242;  bus.req_b_len = 11'd2;  bus.req_b_valid = 1'b1;
    wait_grants(g0 + 1, "s5_grant");
    bus.req_b_valid = 1'b0;
    for (int k = 0; k < 500 && (n_tb - b_tb) < 1; k++) step();
    check("s5_take", 32'(n_tb - b_tb), 32'd1);
    n = 0;
    while (bus.i2c_enable_transfer === 1'b1 && n < 200) begin step(); n++; end
    check("s5_timeout_cycles", 32'(n), 32'd50);
    m = 0;
    while (ne() < e0 + 1 && m < 200) begin step(); m++; end
    check("s5_err_after_idle", 32'(m >= IDLE_WAIT && m <= IDLE_WAIT + 3), 32'd1);
    check("s5_err",  32'(n_eb - b_eb), 32'd1);
    check("s5_done", 32'(n_db - b_db), 32'd0);
    silent_from = -1;

    // Reset during the second DATA byte of a write from A
    for (int i = 0; i < 4; i++) wdat_a[i] = 8'h01 + 8'(i);
    snap();  g0 = ng();
    step();
    bus.req_a_rw = 1'b0;  bus.req_a_reg = 16'h5555;  bus.req_a_len = 11'd4;  bus.req_a_valid = 1'b1;
    wait_grants(g0 + 1, "s6_grant");
    bus.req_a_valid = 1'b0;
    for (int k = 0; k < 500 && (n_ta - b_ta) < 2; k++) step();
    check("s6_take2", 32'(n_ta - b_ta), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_en",   32'(bus.i2c_enable_transfer), 32'd0);
    check("s6_async_busy", 32'(bus.busy), 32'd0);
    check("s6_async_tx",   32'(bus.i2c_transmit_data), 32'h00);
    repeat (3) step();
    reset = 1'b0;
    repeat (60) step();
    check("s6_no_done", 32'(n_da - b_da), 32'd0);
    check("s6_no_err",  32'(n_ea - b_ea), 32'd0);
    bus.req_a_rw = 1'b0;  bus.req_a_reg = 16'h0303;  bus.req_a_len = 11'd0;
    bus.req_b_rw = 1'b0;  bus.req_b_reg = 16'h0404;  bus.req_b_len = 11'd0;
    snap();  g0 = ng();  e0 = ne();
    bus.req_a_valid = 1'b1;  bus.req_b_valid = 1'b1;
    wait_grants(g0 + 1, "s6_post_grant");
    bus.req_a_valid = 1'b0;  bus.req_b_valid = 1'b0;
    check("s6_post_first_a", 32'(gnt_log[gb]), 32'd0);
    wait_end(e0 + 1, "s6_post_end");
    check("s6_post_done", 32'(n_da - b_da), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEV_ADDR, 7'h33, I2C device address driven on i2c_address.
- TIMEOUT_TICKS, 24000, clk cycles allowed per byte before timeout (1 ms at 24 MHz).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock (24 MHz).
- reset, in, 1, asynchronous active-high reset.
- req_a_valid / req_b_valid, in, 1, requester A/B transaction request.
- req_a_rw / req_b_rw, in, 1, 0 = write, 1 = read.
- req_a_reg / req_b_reg, in, 16, target register address, sent MSB byte first.
- req_a_len / req_b_len, in, 11, data byte count, 0..2047.
- wr_a_data / wr_b_data, in, 8, next write byte.
- grant_a / grant_b, out, 1, one-cycle pulse: request accepted.
- wr_a_take / wr_b_take, out, 1, one-cycle pulse: wr_x_data consumed.
- rd_data, out, 8, last read byte (shared).
- rd_a_valid / rd_b_valid, out, 1, one-cycle pulse: rd_data valid for that owner.
- done_a / done_b, out, 1, one-cycle pulse: transaction completed OK.
- err_a / err_b, out, 1, one-cycle pulse: NACK or timeout.
- busy, out, 1, high from grant through return to IDLE.
- i2c_address, out, 7, DEV_ADDR, constant.
- i2c_read_write, out, 1, to byte controller.
- i2c_transmit_data, out, 8, to byte controller.
- i2c_enable_transfer, out, 1, to byte controller.
- i2c_idle / i2c_ack / i2c_nack, in, 1, from byte controller.
- i2c_received_data, in, 8, from byte controller.

Function
REQ-003 i2c_ack/i2c_nack SHALL pass through 2-bit shift monitors; only a 01 pattern (rising edge) counts as a byte success or failure.
REQ-004 States SHALL be: IDLE, REG_HI, REG_LO, SWITCH, DATA, STOP, ERROR.
REQ-005 IDLE: when i2c_idle=1 and any req valid, grant one requester:
- Grant is round-robin; when both are valid, the requester not granted last wins.
- Pointer after reset favours A.
- The grant_x pulse coincides with the IDLE->REG_HI transition.
- rw, reg and len SHALL be latched at grant; the requester may change them afterwards.
REQ-006 REG_HI: read_write=0, transmit_data=reg[15:8], enable=1. On success -> REG_LO.
REQ-007 REG_LO: transmit_data=reg[7:0]. On success:
- len=0 -> STOP.
- read -> SWITCH.
- write -> DATA.
REQ-008 SWITCH: enable=0, read_write=1. When i2c_idle=1 -> DATA with enable=1 (repeated start).
REQ-009 DATA, write: on each DATA-byte start, load transmit_data from wr_x_data with wr_x_take pulsing the same cycle. The requester SHALL present the next byte within 1 cycle.
REQ-010 DATA, read: on each success, rd_data<=i2c_received_data and rd_x_valid pulses exactly 1 cycle later.
REQ-011 DATA SHALL count bytes with an 11-bit down-counter and -> STOP when the count reaches 0.
REQ-012 STOP: enable=0. When i2c_idle=1, done_x pulses, busy=0 -> IDLE.
REQ-013 A failure edge in any byte state -> ERROR.
REQ-014 Timeout: a per-byte counter SHALL clear on each enabled byte start and on each success. If it reaches TIMEOUT_TICKS without an edge -> ERROR.
REQ-015 ERROR: enable=0. When i2c_idle=1, err_x pulses -> IDLE. No done_x is issued for that transaction.
REQ-016 Simultaneous success and failure edges SHALL be treated as failure.
REQ-017 Requests arriving while busy SHALL wait; there is no queueing beyond req_x_valid held high.
REQ-018 Exactly one of done_x/err_x SHALL pulse per grant.

Reset
REQ-019 On reset assertion, asynchronously:
- state=IDLE, i2c_enable_transfer=0, i2c_read_write=0, i2c_transmit_data=0.
- rd_data=0, busy=0.
- All pulse outputs 0, counters 0, RR pointer=A, edge monitors 0.
REQ-020 Reset mid-transaction SHALL produce no done_x/err_x pulse for the aborted transaction.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Read A, reg 16'h2400, len 4, slave ACKs all -> bytes 24,00 sent, SWITCH waits idle, 4 rd_a_valid pulses with model data, one done_a.
- Write B, reg 16'h800D, len 2, data 11,22 -> transmit 80,0D,11,22; two wr_b_take pulses; read_write never 1; done_b.
- A and B valid the same cycle twice in succession -> grants A then B; B then A when the pointer is set to B.
- NACK on REG_LO -> enable drops, err_a after idle, no rd/done pulses, next request serviced normally.
- No ack/nack for TIMEOUT_TICKS=50 in DATA -> err pulse at tick 50+idle wait.
- Reset asserted during DATA byte 2 -> enable=0 same cycle (async); no done/err; after release, IDLE and grants A first.
